// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, software
// source id, FSM encoding and the priority-select helper.
package irq_ctrl_pkg;

  localparam logic [2:0] ADDR_PEND  = 3'd0;
  localparam logic [2:0] ADDR_MASK  = 3'd1;
  localparam logic [2:0] ADDR_EDGE  = 3'd2;
  localparam logic [2:0] ADDR_CUR   = 3'd3;
  localparam logic [2:0] ADDR_EOI   = 3'd4;
  localparam logic [2:0] ADDR_SWSET = 3'd5;

  localparam logic [3:0] SRC_SW    = 4'd15;
  localparam int         MAX_LINES = 15;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set(input logic [14:0] v);
    logic [3:0] id;
    id = 4'd0;
    for (int i = MAX_LINES - 1; i >= 0; i--) begin
      if (v[i]) begin
        id = 4'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line, followed by a
// previous-value flop that yields a one-cycle rising-edge strobe.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line pending/mask/edge configuration, an
// unmaskable software request, fixed priority and a non-nesting IDLE/SERVICE FSM.
module irq_ctrl #(
  parameter int NLINES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NLINES-1:0] irq_lines,
  input  logic              int_req,
  input  logic              take,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [2:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  output logic              irq_out,
  output logic              irq_instr,
  output logic [3:0]        irq_src
);

  import irq_ctrl_pkg::*;

  logic [NLINES-1:0] sync_s;
  logic [NLINES-1:0] rise_s;
  logic [NLINES-1:0] pend_q, pend_d;
  logic [NLINES-1:0] mask_q, mask_d;
  logic [NLINES-1:0] edge_q, edge_d;
  logic [NLINES-1:0] set_s;
  logic [NLINES-1:0] clr_s;
  logic [NLINES-1:0] elig_s;
  logic              swpend_q, swpend_d;
  state_e            state_q, state_d;
  logic [15:0]       cur_q, cur_d;
  logic              any_s;
  logic [3:0]        win_id_s;
  logic              take_ok_s;
  logic              take_line_s;
  logic              wr_pend_s, wr_mask_s, wr_edge_s, wr_eoi_s, wr_swset_s;
  logic              unused_wdata_s;

  for (genvar g = 0; g < NLINES; g++) begin : g_sync
    irq_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (irq_lines[g]),
      .level_o (sync_s[g]),
      .rise_o  (rise_s[g])
    );
  end

  assign wr_pend_s  = cfg_we && (cfg_addr == ADDR_PEND);
  assign wr_mask_s  = cfg_we && (cfg_addr == ADDR_MASK);
  assign wr_edge_s  = cfg_we && (cfg_addr == ADDR_EDGE);
  assign wr_eoi_s   = cfg_we && (cfg_addr == ADDR_EOI);
  assign wr_swset_s = cfg_we && (cfg_addr == ADDR_SWSET);
  assign unused_wdata_s = ^cfg_wdata;

  // Software request outranks every line and ignores MASK.
  assign elig_s      = pend_q & mask_q;
  assign any_s       = swpend_q | (|elig_s);
  assign win_id_s    = swpend_q ? SRC_SW : lowest_set(15'(elig_s));
  assign take_ok_s   = take && (state_q == ST_IDLE) && any_s;
  assign take_line_s = take_ok_s && !swpend_q;

  assign irq_out   = (state_q == ST_IDLE) && any_s;
  assign irq_instr = swpend_q;
  assign irq_src   = win_id_s;

  // Per-line set/clear requests for edge-mode pending bits.
  always_comb begin
    set_s = {NLINES{1'b0}};
    clr_s = {NLINES{1'b0}};
    for (int i = 0; i < NLINES; i++) begin
      set_s[i] = rise_s[i] | (wr_swset_s & cfg_wdata[i]);
      clr_s[i] = (wr_pend_s & cfg_wdata[i]) |
                 (take_line_s & (win_id_s == 4'(i)));
    end
  end

  // Edge lines: set beats clear; level lines mirror the synced input.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NLINES; i++) begin
      if (edge_q[i]) begin
        pend_d[i] = (pend_q[i] & ~clr_s[i]) | set_s[i];
      end else begin
        pend_d[i] = sync_s[i];
      end
    end
  end

  // A new int_req keeps SWPEND set even when the same cycle takes it.
  always_comb begin
    if (int_req) begin
      swpend_d = 1'b1;
    end else if (take_ok_s && swpend_q) begin
      swpend_d = 1'b0;
    end else begin
      swpend_d = swpend_q;
    end
  end

  // Configuration register writes.
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_mask_s) begin
      mask_d = cfg_wdata[NLINES-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_edge_s) begin
      edge_d = cfg_wdata[NLINES-1:0];
    end else begin
      edge_d = edge_q;
    end
  end

  // Service FSM: one interrupt in flight until EOI.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (take_ok_s) begin
          state_d = ST_SERVICE;
          cur_d   = {1'b1, 11'd0, win_id_s};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi_s) begin
          state_d = ST_IDLE;
          cur_d   = 16'd0;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cur_d   = 16'd0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= {NLINES{1'b0}};
      mask_q   <= {NLINES{1'b0}};
      edge_q   <= {NLINES{1'b0}};
      swpend_q <= 1'b0;
      state_q  <= ST_IDLE;
      cur_q    <= 16'd0;
    end else begin
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      swpend_q <= swpend_d;
      state_q  <= state_d;
      cur_q    <= cur_d;
    end
  end

  // Register read mux.
  always_comb begin
    cfg_rdata = 16'd0;
    if (cfg_re) begin
      case (cfg_addr)
        ADDR_PEND: cfg_rdata = 16'(pend_q);
        ADDR_MASK: cfg_rdata = 16'(mask_q);
        ADDR_EDGE: cfg_rdata = 16'(edge_q);
        ADDR_CUR:  cfg_rdata = cur_q;
        default:   cfg_rdata = 16'd0;
      endcase
    end else begin
      cfg_rdata = 16'd0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_irq_ctrl;

  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NL-1:0] lines = '0;
  logic          int_req = 1'b0, take = 1'b0, cfg_we = 1'b0, cfg_re = 1'b0;
  logic [2:0]    cfg_addr = 3'd0;
  logic [15:0]   cfg_wdata = 16'd0;
  logic [15:0]   cfg_rdata;
  logic          irq_out, irq_instr;
  logic [3:0]    irq_src;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.NLINES(NL)) dut (
    .clk(clk), .rst(rst), .irq_lines(lines), .int_req(int_req), .take(take),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .irq_out(irq_out), .irq_instr(irq_instr), .irq_src(irq_src)
  );

  always #5 clk = ~clk;

  // Model: line samples of the last three edges, pending/config bits, service state.
  typedef struct packed {
    logic [NL-1:0] h0, h1, h2;
    logic [NL-1:0] pend, mask, edg;
    logic          sw, busy;
    logic [3:0]    cur_id;
  } mst_t;

  mst_t m;

  function automatic int win_of(mst_t s);
    if (s.sw) return 15;
    for (int i = 0; i < NL; i++) if (s.pend[i] && s.mask[i]) return i;
    return -1;
  endfunction

  function automatic mst_t step(mst_t s, logic [NL-1:0] ln, logic ir, logic tk_in,
                                logic we, logic [2:0] a, logic [15:0] wd);
    mst_t n;
    int w;
    bit tk, st, cl;
    n = s;
    w = win_of(s);
    tk = tk_in && !s.busy && (w >= 0);
    for (int i = 0; i < NL; i++) begin
      if (s.edg[i]) begin
        st = (s.h1[i] && !s.h2[i]) || (we && a == 3'd5 && wd[i]);
        cl = (we && a == 3'd0 && wd[i]) || (tk && w == i);
        n.pend[i] = st ? 1'b1 : (cl ? 1'b0 : s.pend[i]);
      end else begin
        n.pend[i] = s.h1[i];
      end
    end
    n.sw = ir ? 1'b1 : ((tk && w == 15) ? 1'b0 : s.sw);
    if (s.busy && we && a == 3'd4) begin
      n.busy = 1'b0;
      n.cur_id = 4'd0;
    end else if (tk) begin
      n.busy = 1'b1;
      n.cur_id = 4'(w);
    end
    if (we && a == 3'd1) n.mask = wd[NL-1:0];
    if (we && a == 3'd2) n.edg = wd[NL-1:0];
    n.h2 = s.h1;
    n.h1 = s.h0;
    n.h0 = ln;
    return n;
  endfunction

  function automatic logic [15:0] mread(mst_t s, logic [2:0] a);
    case (a)
      3'd0: return {8'h00, s.pend};
      3'd1: return {8'h00, s.mask};
      3'd2: return {8'h00, s.edg};
      3'd3: return s.busy ? {1'b1, 11'd0, s.cur_id} : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [3:0] msrc(mst_t s);
    int w;
    w = win_of(s);
    return (w >= 0) ? 4'(w) : 4'd0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else m <= step(m, lines, int_req, take, cfg_we, cfg_addr, cfg_wdata);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin : cmp
    chk("irq_out", {31'd0, irq_out}, {31'd0, (!m.busy && win_of(m) >= 0)});
    chk("irq_src", {28'd0, irq_src}, {28'd0, msrc(m)});
    chk("irq_instr", {31'd0, irq_instr}, {31'd0, m.sw});
    if (cfg_re) chk("cfg_rdata", {16'd0, cfg_rdata}, {16'd0, mread(m, cfg_addr)});
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      int_req = 1'b0; take = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [15:0] exp);
    cfg_re = 1'b1; cfg_addr = a;
    #1;
    chk(nm, {16'd0, cfg_rdata}, {16'd0, exp});
    chk({nm, "_model"}, {16'd0, mread(m, a)}, {16'd0, exp});
    cyc();
  endtask

  task automatic chk_out(input string nm, input logic o, input logic [3:0] src, input logic ins);
    chk({nm, "_out"}, {31'd0, irq_out}, {31'd0, o});
    chk({nm, "_src"}, {28'd0, irq_src}, {28'd0, src});
    chk({nm, "_instr"}, {31'd0, irq_instr}, {31'd0, ins});
    chk({nm, "_model_out"}, {31'd0, (!m.busy && win_of(m) >= 0)}, {31'd0, o});
    chk({nm, "_model_src"}, {28'd0, msrc(m)}, {28'd0, src});
  endtask

  initial begin
    cyc(2);
    chk_out("reset", 1'b0, 4'd0, 1'b0);
    rd("reset_pend", 3'd0, 16'h0000);
    rst = 1'b1;
    cyc();

    // Single edge line through take and EOI
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h0001);
    lines = 8'h01;
    cyc(2);
    chk_out("lat_n1", 1'b0, 4'd0, 1'b0);
    cyc();
    chk_out("lat_n2", 1'b1, 4'd0, 1'b0);
    take = 1'b1;
    cyc();
    rd("take_cur", 3'd3, 16'h8000);
    rd("take_pend", 3'd0, 16'h0000);
    chk_out("take", 1'b0, 4'd0, 1'b0);
    wr(3'd4, 16'h1234);
    lines = 8'h00;

    // Simultaneous edges on lines 3 and 5
    wr(3'd1, 16'h00FF);
    lines = 8'h28;
    cyc(3);
    chk_out("prio35", 1'b1, 4'd3, 1'b0);
    take = 1'b1;
    cyc();
    chk_out("svc3", 1'b0, 4'd5, 1'b0);
    rd("cur3", 3'd3, 16'h8003);
    wr(3'd4, 16'h0000);
    chk_out("next5", 1'b1, 4'd5, 1'b0);
    take = 1'b1;
    cyc();
    rd("cur5", 3'd3, 16'h8005);
    wr(3'd4, 16'h0000);
    chk_out("done35", 1'b0, 4'd0, 1'b0);
    lines = 8'h00;

    // Software interrupt preempts a pending line
    lines = 8'h04;
    cyc(3);
    chk_out("l2", 1'b1, 4'd2, 1'b0);
    int_req = 1'b1;
    cyc();
    chk_out("sw", 1'b1, 4'd15, 1'b1);
    take = 1'b1;
    cyc();
    rd("cur_sw", 3'd3, 16'h800F);
    wr(3'd4, 16'h0000);
    chk_out("after_sw", 1'b1, 4'd2, 1'b0);
    take = 1'b1;
    cyc();
    rd("cur2", 3'd3, 16'h8002);
    wr(3'd4, 16'h0000);
    lines = 8'h00;
    chk_out("idle", 1'b0, 4'd0, 1'b0);

    // Level-mode line drops before being taken
    wr(3'd2, 16'h00EF);
    lines = 8'h10;
    cyc(3);
    chk_out("lvl_hi", 1'b1, 4'd4, 1'b0);
    rd("lvl_pend", 3'd0, 16'h0010);
    lines = 8'h00;
    cyc(3);
    chk_out("lvl_lo", 1'b0, 4'd0, 1'b0);
    rd("lvl_pend0", 3'd0, 16'h0000);

    // W1C colliding with a new edge: set wins
    wr(3'd2, 16'h00FF);
    lines = 8'h02;
    cyc(2);
    wr(3'd0, 16'h0002);
    rd("w1c_race", 3'd0, 16'h0002);
    wr(3'd0, 16'h0002);
    rd("w1c", 3'd0, 16'h0000);
    lines = 8'h00;

    // Reset during SERVICE with PEND=0x0C
    int_req = 1'b1;
    cyc();
    take = 1'b1;
    cyc();
    wr(3'd5, 16'h000C);
    rd("swset", 3'd0, 16'h000C);
    rst = 1'b0;
    #1;
    rd("rst_pend", 3'd0, 16'h0000);
    rd("rst_mask", 3'd1, 16'h0000);
    rd("rst_cur", 3'd3, 16'h0000);
    chk_out("rst_svc", 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    cyc();
    take = 1'b1;
    cyc();
    rd("take_ignored", 3'd3, 16'h0000);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        int idx;
        idx = int'($urandom_range(0, NL - 1));
        lines[idx] = ~lines[idx];
      end
      int_req = ($urandom_range(0, 31) == 0);
      take = ($urandom_range(0, 2) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_re = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 4) == 0) begin
        cfg_we = 1'b1;
        cfg_wdata = 16'($urandom);
      end
      rst = ($urandom_range(0, 999) != 0);
      cyc();
    end
    rst = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NLINES, default 8, number of external interrupt lines (1..15).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 irq_lines  in  NLINES  external requests, asynchronous to clk.
REQ-005 int_req  in  1  one-cycle pulse from decoder on 'int' instruction.
REQ-006 take  in  1  core accepted interrupt this cycle (irq_out & irq_en & (pc_ie|pc_inc)).
REQ-007 cfg_we, cfg_re  in  1 each  special-register write/read strobes.
REQ-008 cfg_addr  in  3  register select; cfg_wdata  in  16  write data; cfg_rdata  out  16  read data, combinational.
REQ-009 irq_out  out  1  request to special-register block irq_in.
REQ-010 irq_instr  out  1  selected source is software 'int'.
REQ-011 irq_src  out  4  selected source id: 0..NLINES-1 lines, 15 software.

Function
REQ-012 Each line SHALL pass a 2-flop synchronizer, then a previous-value flop for edge detect.
REQ-013 EDGE[i]=1: rising edge of synced line SHALL set PEND[i]; EDGE[i]=0: PEND[i] SHALL follow synced level.
REQ-014 Latency: line high before edge N SHALL make irq_out high after edge N+2 (idle, unmasked).
REQ-015 int_req SHALL set SWPEND; SWPEND SHALL be unmaskable and highest priority.
REQ-016 Among PEND & MASK, lowest index SHALL win; irq_src/irq_instr combinational from winner.
REQ-017 FSM states IDLE, SERVICE; irq_out SHALL be high only in IDLE with any eligible request.
REQ-018 IDLE + take + eligible request: SHALL latch winner into CUR, clear its edge-pend bit (or SWPEND), go SERVICE.
REQ-019 take with no eligible request, or take in SERVICE, SHALL be ignored.
REQ-020 SERVICE: write to EOI SHALL return to IDLE next edge; no nesting.
REQ-021 Registers: 0 PEND (R; W1C edge bits only), 1 MASK (RW), 2 EDGE (RW), 3 CUR (R: bit15 valid, [3:0] id), 4 EOI (W, data ignored), 5 SWSET (W: bit i sets PEND[i] for edge lines). Others read 0, writes ignored.
REQ-022 Unused high bits SHALL read 0; level-line PEND bits SHALL ignore W1C and SWSET.
REQ-023 Same-cycle hardware set and W1C of one PEND bit: set SHALL win.
REQ-024 Same-cycle take and W1C clearing the winner: take SHALL still latch winner.
REQ-025 Same-cycle int_req and take selecting SWPEND: SWPEND SHALL remain set.
REQ-026 MASK change SHALL affect irq_out the same cycle it becomes visible (next edge after write).
REQ-027 Edges during SERVICE SHALL accumulate in PEND, served after EOI.

Reset
REQ-028 rst low SHALL asynchronously clear sync/prev flops, PEND, SWPEND, MASK, EDGE (all level), CUR, force IDLE.
REQ-029 During/after reset irq_out, irq_instr SHALL be 0, irq_src 0, until first eligible request.
REQ-030 Reset mid-SERVICE SHALL drop CUR; no EOI required.

Structure
REQ-031 Register addresses, source id 15 (SW), FSM encoding SHALL be in shared core package.
REQ-032 Synchronizer+edge detect SHALL be sub-module irq_sync, instantiated per line.

Verification
REQ-033 Reset, EDGE=0xFF, MASK=0x01, line0 rises -> irq_out high 3 edges later, irq_src=0; take -> CUR=0x8000, PEND=0, irq_out 0.
REQ-034 Lines 3 and 5 rise same cycle, MASK=0xFF -> src 3 served; EOI -> src 5 served next.
REQ-035 int_req while line 2 pending -> irq_src=15, irq_instr=1; take then EOI -> src 2.
REQ-036 EDGE[4]=0, line 4 held high then dropped before take -> irq_out falls, PEND[4]=0.
REQ-037 W1C of PEND[1] same cycle as new edge on line 1 -> PEND[1] stays 1.
REQ-038 rst low during SERVICE with PEND=0x0C -> PEND=0, MASK=0, CUR=0, irq_out 0.
